// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul result collection path.
package matmul_pkg;

    localparam int VEC_LEN    = 4;
    localparam int MAT_ELEMS  = 16;
    localparam int SP_LATENCY = 4;
    localparam int NUM_BANKS  = 2;
    localparam int IDX_W      = $clog2(MAT_ELEMS);
    localparam int OCC_MAX    = NUM_BANKS * MAT_ELEMS;
    localparam int OCC_W      = $clog2(OCC_MAX + 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Async-reset shift register tracking which cycles carry an issued A/B pair.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    // Shift the new valid bit in at position 0, oldest tap at DEPTH-1.
    always_comb begin
        shift_d    = shift_q;
        shift_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    // Delay line storage; reset drops every in-flight marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign dout = shift_q[DEPTH-1];

endmodule

// File: rtl/matmul_result_collector.sv
// Collects scalar_product results into ping-pong 4x4 matrix banks and
// presents each completed matrix on a valid/ready port.
module matmul_result_collector
    import matmul_pkg::*;
#(
    parameter int Nbits   = 8,
    parameter int LATENCY = SP_LATENCY
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [2*Nbits-1:0]           prod_in,
    output logic [MAT_ELEMS*2*Nbits-1:0] mat_out,
    output logic                         mat_valid,
    input  logic                         mat_ready,
    output logic                         busy
);

    localparam int PW = 2 * Nbits;

    logic              issue_fire;
    logic              wr_en;
    logic              drain;

    logic [IDX_W-1:0]  wr_idx_q,  wr_idx_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [OCC_W-1:0]  occ_q,     occ_d;
    bank_state_t       bank_state_q [NUM_BANKS];
    bank_state_t       bank_state_d [NUM_BANKS];
    logic [PW-1:0]     bank_data_q  [NUM_BANKS][MAT_ELEMS];
    logic [PW-1:0]     bank_data_d  [NUM_BANKS][MAT_ELEMS];

    assign issue_fire = issue_valid & issue_ready;
    assign drain      = mat_valid & mat_ready;

    // The tap at depth LATENCY lines up with prod_in carrying that pair's result.
    valid_delay_line #(
        .DEPTH (LATENCY)
    ) u_valid_delay_line (
        .clk   (clk),
        .reset (reset),
        .din   (issue_fire),
        .dout  (wr_en)
    );

    // Next-state: capture writes, per-bank state transitions, pointers, occupancy.
    always_comb begin
        wr_idx_d     = wr_idx_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        bank_state_d = bank_state_q;
        bank_data_d  = bank_data_q;

        if (wr_en) begin
            bank_data_d[wr_bank_q][wr_idx_q] = prod_in;
            wr_idx_d = wr_idx_q + IDX_W'(1);
            if (wr_idx_q == IDX_W'(MAT_ELEMS - 1)) begin
                bank_state_d[wr_bank_q] = FULL;
                wr_bank_d               = ~wr_bank_q;
            end else begin
                bank_state_d[wr_bank_q] = FILLING;
            end
        end

        // Drain only touches a FULL bank, which is never the write bank,
        // so it cannot collide with the write transition above.
        if (drain) begin
            bank_state_d[rd_bank_q] = EMPTY;
            rd_bank_d               = ~rd_bank_q;
        end

        occ_d = occ_q + OCC_W'(issue_fire) - (drain ? OCC_W'(MAT_ELEMS) : OCC_W'(0));
    end

    // State register; reset discards in-flight products and clears all bank data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            occ_q     <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state_q[b] <= EMPTY;
                for (int e = 0; e < MAT_ELEMS; e++) begin
                    bank_data_q[b][e] <= '0;
                end
            end
        end else begin
            wr_idx_q     <= wr_idx_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            occ_q        <= occ_d;
            bank_state_q <= bank_state_d;
            bank_data_q  <= bank_data_d;
        end
    end

    // Outputs from registered state only; occupancy is nonzero exactly when a
    // product is in flight or sits in a non-EMPTY bank.
    always_comb begin
        mat_valid   = (bank_state_q[rd_bank_q] == FULL);
        issue_ready = (occ_q < OCC_W'(OCC_MAX));
        busy        = (occ_q != '0);
    end

    // Row-major matrix view of the read bank.
    for (genvar gi = 0; gi < MAT_ELEMS; gi++) begin : g_mat_out
        assign mat_out[gi*PW +: PW] = bank_data_q[rd_bank_q][gi];
    end

endmodule

// File: tb/tb_matmul_result_collector.sv
// Scoreboard bench for matmul_result_collector with a transaction-level model.
module tb_matmul_result_collector;
    import matmul_pkg::*;

    localparam int NB  = 8;
    localparam int PW  = 2 * NB;
    localparam int LAT = SP_LATENCY;
    localparam int MW  = MAT_ELEMS * PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [PW-1:0] prod_in = '0;
    logic [MW-1:0] mat_out;
    logic          mat_valid;
    logic          mat_ready = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    matmul_result_collector #(
        .Nbits   (NB),
        .LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .prod_in     (prod_in),
        .mat_out     (mat_out),
        .mat_valid   (mat_valid),
        .mat_ready   (mat_ready),
        .busy        (busy)
    );

    typedef struct {
        logic [MW-1:0] data;
        int            ready_edge;
    } mat_t;

    int            checks   = 0;
    int            failures = 0;
    int            edge_cnt = 0;
    logic [PW-1:0] cur_prod = '0;
    mat_t          exp_q[$];
    logic [MW-1:0] group_data = '0;
    int            group_n  = 0;
    int            occ_m    = 0;
    int            n_drained = 0;
    logic [PW-1:0] sched[int];

    task automatic check_val(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edge_cnt, act, exp);
        end
    endtask

    // Dot product of two 4-element byte vectors, kept to the product width.
    function automatic logic [PW-1:0] dot4(input logic [31:0] a, input logic [31:0] b);
        int sum = 0;
        for (int j = 0; j < VEC_LEN; j++) sum += int'(a[8*j +: 8]) * int'(b[8*j +: 8]);
        return PW'(sum);
    endfunction

    function automatic logic [PW-1:0] rand_prod();
        return dot4($urandom, $urandom);
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Upstream pipe stand-in: the product of an issue accepted at edge k is
    // held on prod_in for edge k+LAT; anything else is noise.
    always @(posedge clk) begin
        #1;
        if (sched.exists(edge_cnt + 1)) prod_in = sched[edge_cnt + 1];
        else                            prod_in = PW'($urandom);
    end

    // Monitor: checks outputs mid-cycle, then advances the model to the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            bit exp_valid;
            bit acc;
            exp_valid = (exp_q.size() > 0) && (edge_cnt >= exp_q[0].ready_edge);
            check_val("mat_valid", MW'(mat_valid), MW'(exp_valid));
            if (exp_valid) check_val("mat_out", mat_out, exp_q[0].data);
            check_val("issue_ready", MW'(issue_ready), MW'(occ_m < 32));
            check_val("busy", MW'(busy), MW'(occ_m != 0));
            if (dut.wr_en) check_val("bank_overwrite", MW'(dut.bank_state_q[dut.wr_bank_q] == FULL), MW'(0));

            acc = issue_valid && (occ_m < 32);
            if (acc) begin
                group_data[group_n*PW +: PW] = cur_prod;
                sched[edge_cnt + 1 + LAT]    = cur_prod;
                group_n++;
                occ_m++;
                if (group_n == MAT_ELEMS) begin
                    exp_q.push_back('{data: group_data, ready_edge: edge_cnt + 1 + LAT});
                    group_n = 0;
                end
            end
            if (exp_valid && mat_ready) begin
                void'(exp_q.pop_front());
                occ_m -= MAT_ELEMS;
                n_drained++;
                $display("drain #%0d at edge %0d", n_drained, edge_cnt + 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input logic [PW-1:0] p, input bit mr);
        issue_valid = iv;
        cur_prod    = p;
        mat_ready   = mr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_mat_valid"},   MW'(mat_valid),   MW'(0));
        check_val({tag, "_mat_out"},     mat_out,          MW'(0));
        check_val({tag, "_busy"},        MW'(busy),        MW'(0));
        check_val({tag, "_issue_ready"}, MW'(issue_ready), MW'(1));
    endtask

    // Asynchronous reset mid-cycle; model state is discarded with it.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        drive(1'b0, '0, 1'b0);
        exp_q.delete();
        sched.delete();
        group_n    = 0;
        group_data = '0;
        occ_m      = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d actual=running required=finished", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        bit ready_now;

        // Power-on reset.
        #2;
        check_reset_outputs("por");
        step();
        step();
        rst = 1'b0;
        step();

        // Single matrix: A=B={1,1,1,i} gives 3+i*i.
        for (int i = 0; i < MAT_ELEMS; i++) begin
            logic [31:0] v;
            v = {8'(i), 8'd1, 8'd1, 8'd1};
            drive(1'b1, dot4(v, v), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < LAT + 2; i++) step();
        drive(1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        step();
        check_val("single_idle_busy", MW'(busy), MW'(0));

        // Back-pressure: issue continuously with no drain until ready falls.
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            ready_now = issue_ready;
            drive(1'b1, rand_prod(), 1'b0);
            step();
            if (ready_now) n_acc++;
            if (!issue_ready) break;
        end
        check_val("bp_accept_count", MW'(n_acc), MW'(32));
        // Last accept was just now (edge E); bank 1 completes at E+LAT.
        for (int i = 0; i < LAT - 1; i++) begin
            drive(1'b1, rand_prod(), 1'b0);
            step();
        end
        // At occupancy 32 issue and drain together; drain lands on the same
        // edge the second bank goes FULL.
        drive(1'b1, rand_prod(), 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        check_val("sim_ready_back", MW'(issue_ready), MW'(1));
        check_val("sim_valid_stays", MW'(mat_valid), MW'(1));
        step();
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step();

        // Streaming: 64 back-to-back with the consumer always ready.
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, rand_prod(), 1'b1);
            step();
        end
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < LAT + 4; i++) step();

        // Reset mid-operation: 7 issues, reset with 3 still in flight.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, rand_prod(), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        step();
        async_reset("midrst");
        for (int i = 0; i < MAT_ELEMS; i++) begin
            drive(1'b1, rand_prod(), 1'b1);
            step();
        end
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < LAT + 4; i++) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(3, 0) != 0, rand_prod(), $urandom_range(1, 0) == 1);
            step();
        end
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 40; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_result_collector.md
# matmul_result_collector

Downstream companion of the 4-term pipelined `scalar_product` stage. It tracks which issued A/B pairs are in flight through the fixed-latency dot-product pipe, captures each `out` word when it emerges, and assembles 16 consecutive products into a row-major 4x4 result matrix. The matrix is presented on a valid/ready port. Two ping-pong banks let collection continue while a finished matrix is drained. `issue_ready` back-pressures the upstream feeder so no in-flight product is ever lost.

## Interface

**Parameters**
- `Nbits`, 8: operand width of `scalar_product`. Product width is `2*Nbits`.
- `LATENCY`, 4: edges from A/B being presented to `out` holding the result. Must match `scalar_product`.

**Ports**
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high.
- `issue_valid`, in, 1: upstream presents an A/B pair to `scalar_product` this cycle.
- `issue_ready`, out, 1: collector can accept that product. Upstream issues only when `issue_valid & issue_ready`.
- `prod_in`, in, `2*Nbits`: connected to `scalar_product.out`.
- `mat_out`, out, `16*2*Nbits`: element `(r,c)` at bits `[(4r+c)*2Nbits +: 2Nbits]`.
- `mat_valid`, out, 1: `mat_out` holds a complete matrix.
- `mat_ready`, in, 1: consumer accepts the matrix.
- `busy`, out, 1: any product in flight or any bank not EMPTY.

## Operation

- **Issue handshake:** an issue is accepted when `issue_valid & issue_ready` at a clk edge.
- **Valid delay line:** each accepted issue enters a `LATENCY`-deep shift register. When the tap at depth `LATENCY` is 1, `prod_in` is written to `bank[wr_bank][wr_idx]`.
- **Write pointers:**
  - `wr_idx` runs 0..15 and increments on each write.
  - On the write at index 15, the bank goes FULL, `wr_idx` wraps to 0 and `wr_bank` toggles.
- **Bank states:** EMPTY, FILLING, FULL.
  - EMPTY→FILLING on the first write to the bank.
  - FILLING→FULL on the 16th write.
  - FULL→EMPTY on drain.
- **Drain:**
  - `mat_valid = (state[rd_bank] == FULL)`, and `mat_out = bank[rd_bank]`.
  - On `mat_valid & mat_ready`, that bank goes EMPTY and `rd_bank` toggles.
- **Occupancy counter** (0..32) counts accepted issues not yet drained:
  - +1 per accepted issue.
  - −16 per drain.
  - A simultaneous issue and drain gives a net −15.
- **Ready:** `issue_ready = (occupancy < 32)`. This is combinational from registered state and never depends on `issue_valid`.
- **Arithmetic:** products are stored unmodified, `2*Nbits` wide. No truncation and no extension.
- **Simultaneous events:**
  - Writing index 15 of one bank while the other bank drains in the same edge is legal. Both transitions apply.
  - A write into a bank that is not EMPTY/FILLING is impossible by construction. The bench asserts this.
- **Reset (async, any time):**
  - Clears the delay line, occupancy, `wr_idx`, `wr_bank`, `rd_bank`, all bank states (EMPTY) and all bank data (0).
  - In-flight products are discarded.
  - Upstream's synchronous-reset pipe must see at least one clk edge under reset before issuing.

## Timing

- **Reset values:**
  - `mat_valid` = 0, `mat_out` = 0, `busy` = 0.
  - `issue_ready` = 1.
- **Issue to write:** an issue accepted at edge k is written at edge k+`LATENCY`.
- **Issue to matrix:** with issues at edges 0..15, the last write is at edge 19 and `mat_valid` is high from edge 19 onward.
- **Drain:** `mat_valid` falls the edge after the handshake unless the other bank is already FULL. In that case it stays high with the new data.
- **Ready:** `issue_ready` drops the edge the 32nd undrained issue is accepted. It rises the edge after a drain handshake.
- **Throughput:** one product per cycle with no bubbles, provided the consumer drains each matrix within 16 cycles.

## Structure

- **Package `matmul_pkg`:** constants `VEC_LEN=4`, `MAT_ELEMS=16`, `SP_LATENCY=4`, and a `bank_state_t` enum (EMPTY, FILLING, FULL). `scalar_product` integration uses `SP_LATENCY` as the default for `LATENCY`.
- **Sub-module `valid_delay_line`:** parameters `DEPTH`; ports `clk`, `reset`, `din`, `dout`. It is an async-reset shift register, reusable by the upstream feeder.

## Test plan

- **Single matrix:** issue 16 pairs where pair i is A=B={1,1,1,i} (`Nbits`=8), so `prod_in` = 3+i² at edges i+4. `mat_out` element i = 3+i². `mat_valid` rises at edge 19. Hold `mat_ready`=1 one cycle, then `mat_valid`=0 and `busy`=0.
- **Back-pressure:** hold `mat_ready`=0 and issue continuously. `issue_ready` falls after exactly 32 accepted issues. Both banks are FULL; bank 0 holds products 0..15 and bank 1 holds 16..31. Draining once restores `issue_ready` the next edge.
- **Streaming:** issue 64 pairs back-to-back with `mat_ready`=1. Four matrices appear at edges 19, 35, 51, 67. `issue_ready` stays 1 throughout, with no dropped or reordered element.
- **Simultaneous events:** at occupancy 32, assert `issue_valid` and `mat_ready` in the same cycle. The drain is taken and `issue_ready` returns 1 on the following edge. Also cover a bank going FULL in the same edge the other bank drains: `rd_bank` points to the new FULL bank and `mat_valid` stays 1.
- **Reset mid-operation:** assert `reset` asynchronously after 7 issues, with 3 still in flight. All outputs go to reset values immediately and no late product is written. A fresh 16-issue sequence yields a correct matrix at bank 0.
